vga_timing_gen: RTL
===================

Name: vga_timing_gen

Overview:
- Parametrised VGA timing generator for the display path. Produces the HS/VS/DE strobes, the pixel and line counters, and frame/line start pulses.
- Timing is programmed through a shadow register set. A new timing applies only at a frame boundary, so a reprogram never produces a torn frame.
- HS/VS/DE are delayed by a configurable number of stages to line up with a downstream pixel pipeline. RGB is blanked outside the display area.

Parameters:
- H_W, 12, width of the horizontal timing fields and hcount.
- V_W, 11, width of the vertical timing fields and vcount.
- RGB_W, 12, pixel data width.
- PIPE_DEPTH, 0, extra register stages on hs/vs/de after the base output register (0..8).
- HS_POL, 0, hsync level during the sync interval (0 = active-low).
- VS_POL, 0, vsync level during the sync interval.

Ports:
- clk_i  in  1  pixel clock
- arstn_i  in  1  asynchronous, active-low reset
- en_i  in  1  run enable; sampled only in IDLE and at frame end
- we_i  in  1  write hd..vb into the shadow set
- hd_i/hf_i/hr_i/hb_i  in  H_W each  horizontal display / front porch / sync / back porch
- vd_i/vf_i/vr_i/vb_i  in  V_W each  vertical counterparts, in lines
- cfg_pending_o  out  1  shadow written, not yet committed
- cfg_err_o  out  1  sticky; last commit attempt was rejected as invalid; cleared by next valid commit
- running_o  out  1  FSM in RUN
- hcount_o  out  H_W  current pixel column (undelayed)
- vcount_o  out  V_W  current line (undelayed)
- line_start_o  out  1  1-cycle pulse when hcount==0 in RUN (undelayed)
- frame_start_o  out  1  1-cycle pulse when hcount==0 and vcount==0 in RUN (undelayed)
- hs_o  out  1  delayed horizontal sync
- vs_o  out  1  delayed vertical sync
- de_o  out  1  delayed display enable
- rgb_i  in  RGB_W  pixel from the pipeline, already aligned with de_o
- rgb_o  out  RGB_W  rgb_i when de_o=1, else 0 (combinational)

Behaviour:
- Reset values:
  - Shadow and active sets = 0; cfg_pending_o = 0; cfg_err_o = 0.
  - FSM in IDLE; counters = 0.
  - hs_o = ~HS_POL, vs_o = ~VS_POL; de_o, rgb_o and pulses = 0; all pipeline stages hold the inactive values.
- Shadow write:
  - we_i=1: shadow <= inputs and pending <= 1. Last write wins.
- Validity of a timing set:
  - Every field must be >= 1.
  - The sum must be <= 2^W, computed at W+2 bits (W = H_W or V_W as appropriate).
  - htotal/vtotal are stored at W+1 bits.
- FSM IDLE:
  - Counters are held at 0; strobes inactive.
  - If pending: commit the shadow on the next cycle and clear pending.
  - If the committed set is valid and en_i=1, go to RUN with counters at 0.
  - If the committed set is invalid, set cfg_err_o.
- FSM RUN:
  - hcount increments every cycle and wraps to 0 at htotal-1.
  - At that wrap, vcount increments and wraps to 0 at vtotal-1.
- Frame end: hcount==htotal-1 and vcount==vtotal-1.
  - If pending: active <= shadow (the registered value), pending <= 0.
  - If the new set is invalid: cfg_err_o <= 1 and go to IDLE.
  - If en_i=0: go to IDLE.
  - Otherwise continue in RUN from (0,0) under the new timing.
- we_i in the same cycle as frame end:
  - The write lands in the shadow and pending stays 1.
  - The commit at this boundary uses the pre-write shadow.
  - The new values apply at the next frame end.
- Region decode (from the active set and undelayed counters):
  - de = hcount<hd and vcount<vd.
  - hsync interval = hd+hf <= hcount < hd+hf+hr.
  - vsync interval = vd+vf <= vcount < vd+vf+vr (whole lines).
- Output levels: hs = HS_POL inside the hsync interval, ~HS_POL outside; vs likewise with VS_POL.
- Latency: hs/vs/de are registered once, then pass through PIPE_DEPTH further stages, giving 1+PIPE_DEPTH cycles after the counters.
- Reset mid-frame: everything returns to reset values immediately and the pipeline is flushed.

Decomposition:
- Shared package vga_pkg:
  - timing struct types vga_htiming_t / vga_vtiming_t (d,f,r,b), parametrised by width via typedef in the instantiating scope or fixed max widths;
  - FSM enum {IDLE_S, RUN_S};
  - constant VGA_MAX_PIPE_DEPTH = 8.
- One sub-module, vga_delay_line: WIDTH×DEPTH shift register with asynchronous reset to a parameter value RESET_VAL; passes data straight through when DEPTH=0.

Test Plan:
- Base frame timing: reset; write h=4/1/2/1, v=3/1/1/1; en_i=1; PIPE_DEPTH=0.
  - htotal=8, vtotal=6.
  - frame_start_o every 48 cycles.
  - hs_o low when hcount was 5,6 (one cycle later).
  - vs_o low on line 4; de_o high for 12 cycles per frame.
- Mid-frame reconfig: write hd=6 at vcount=2.
  - cfg_pending_o=1 and the old 8-cycle lines continue until frame end.
  - The next frame has 10-cycle lines; pending returns to 0.
- Write at frame end: we_i asserted exactly at (7,5).
  - The frame after next uses the new values; pending stays 1 for one frame.
- Invalid commit: commit hf_i=0 while running.
  - At frame end: cfg_err_o=1, running_o=0, counters held at 0, hs_o/vs_o inactive.
  - A later valid write restarts the generator and clears cfg_err_o.
- Polarity and delay: HS_POL=1, PIPE_DEPTH=3 → hs_o high during sync and 4 cycles behind hcount; rgb_i=0xABC appears on rgb_o only while de_o=1.
- Reset mid-frame: arstn_i low at hcount=3, vcount=1 → all outputs at reset values in the same cycle; after release, IDLE until a new we_i.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared types and helpers for the VGA timing generator: timing field structs,
// FSM encoding and the timing-set validity rule.
package vga_pkg;

    localparam int VGA_MAX_PIPE_DEPTH = 8;
    // Fields are held at a fixed maximum width; H_W/V_W must not exceed it.
    localparam int VGA_FIELD_W = 16;

    typedef logic [VGA_FIELD_W-1:0] vga_field_t;
    typedef logic [VGA_FIELD_W+1:0] vga_sum_t;

    typedef struct packed {
        vga_field_t d;
        vga_field_t f;
        vga_field_t r;
        vga_field_t b;
    } vga_htiming_t;

    typedef struct packed {
        vga_field_t d;
        vga_field_t f;
        vga_field_t r;
        vga_field_t b;
    } vga_vtiming_t;

    typedef enum logic {IDLE_S, RUN_S} vga_state_e;

    function automatic vga_sum_t vga_sum(vga_field_t d, vga_field_t f, vga_field_t r, vga_field_t b);
        return {2'b00, d} + {2'b00, f} + {2'b00, r} + {2'b00, b};
    endfunction

    // A set is usable when no field is zero and the total fits in w counter bits.
    function automatic logic vga_set_ok(vga_field_t d, vga_field_t f, vga_field_t r, vga_field_t b,
                                        vga_sum_t sum, int unsigned w);
        return (d != '0) && (f != '0) && (r != '0) && (b != '0) &&
               (sum <= (vga_sum_t'(1) << w));
    endfunction

endpackage

// File: rtl/vga_delay_line.sv
// WIDTH x DEPTH shift register with asynchronous reset to RESET_VAL;
// a DEPTH of zero is a plain wire.
module vga_delay_line #(
    parameter int               WIDTH     = 1,
    parameter int               DEPTH     = 0,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk_i,
    input  logic             arstn_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    if (DEPTH == 0) begin : g_bypass
        logic unused_clk_rst;
        assign unused_clk_rst = clk_i ^ arstn_i;
        assign q_o = d_i;
    end else begin : g_shift
        logic [WIDTH-1:0] stage_q [DEPTH];

        always_ff @(posedge clk_i or negedge arstn_i) begin
            if (!arstn_i) begin
                for (int i = 0; i < DEPTH; i++) stage_q[i] <= RESET_VAL;
            end else begin
                stage_q[0] <= d_i;
                for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
            end
        end

        assign q_o = stage_q[DEPTH-1];
    end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA timing generator: shadow/active timing sets committed at frame boundaries,
// pixel/line counters, region decode and delayed HS/VS/DE strobes.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_W        = 12,
    parameter int V_W        = 11,
    parameter int RGB_W      = 12,
    parameter int PIPE_DEPTH = 0,
    parameter bit HS_POL     = 1'b0,
    parameter bit VS_POL     = 1'b0
) (
    input  logic             clk_i,
    input  logic             arstn_i,
    input  logic             en_i,
    input  logic             we_i,
    input  logic [H_W-1:0]   hd_i,
    input  logic [H_W-1:0]   hf_i,
    input  logic [H_W-1:0]   hr_i,
    input  logic [H_W-1:0]   hb_i,
    input  logic [V_W-1:0]   vd_i,
    input  logic [V_W-1:0]   vf_i,
    input  logic [V_W-1:0]   vr_i,
    input  logic [V_W-1:0]   vb_i,
    output logic             cfg_pending_o,
    output logic             cfg_err_o,
    output logic             running_o,
    output logic [H_W-1:0]   hcount_o,
    output logic [V_W-1:0]   vcount_o,
    output logic             line_start_o,
    output logic             frame_start_o,
    output logic             hs_o,
    output logic             vs_o,
    output logic             de_o,
    input  logic [RGB_W-1:0] rgb_i,
    output logic [RGB_W-1:0] rgb_o
);

    vga_htiming_t sh_h_q, act_h_q;
    vga_vtiming_t sh_v_q, act_v_q;
    logic         pend_q, pend_d;
    logic         err_q, err_d;
    logic         act_ok_q;
    vga_state_e   state_q, state_d;
    logic [H_W-1:0] hcnt_q, hcnt_d;
    logic [V_W-1:0] vcnt_q, vcnt_d;
    logic [H_W:0]   htot_q;
    logic [V_W:0]   vtot_q;
    logic         hs_q, vs_q, de_q;
    logic         commit;

    vga_sum_t sh_hsum, sh_vsum;
    logic     sh_ok;
    assign sh_hsum = vga_sum(sh_h_q.d, sh_h_q.f, sh_h_q.r, sh_h_q.b);
    assign sh_vsum = vga_sum(sh_v_q.d, sh_v_q.f, sh_v_q.r, sh_v_q.b);
    assign sh_ok   = vga_set_ok(sh_h_q.d, sh_h_q.f, sh_h_q.r, sh_h_q.b, sh_hsum, H_W) &&
                     vga_set_ok(sh_v_q.d, sh_v_q.f, sh_v_q.r, sh_v_q.b, sh_vsum, V_W);

    logic h_last, v_last, running;
    assign h_last  = ({1'b0, hcnt_q} == htot_q - (H_W+1)'(1));
    assign v_last  = ({1'b0, vcnt_q} == vtot_q - (V_W+1)'(1));
    assign running = (state_q == RUN_S);

    always_comb begin
        state_d = state_q;
        hcnt_d  = hcnt_q;
        vcnt_d  = vcnt_q;
        pend_d  = pend_q;
        err_d   = err_q;
        commit  = 1'b0;
        case (state_q)
            IDLE_S: begin
                hcnt_d = '0;
                vcnt_d = '0;
                if (pend_q) begin
                    commit = 1'b1;
                    pend_d = 1'b0;
                    err_d  = ~sh_ok;
                end else if (act_ok_q && en_i) begin
                    state_d = RUN_S;
                end
            end
            RUN_S: begin
                if (h_last) begin
                    hcnt_d = '0;
                    vcnt_d = v_last ? '0 : vcnt_q + V_W'(1);
                end else begin
                    hcnt_d = hcnt_q + H_W'(1);
                end
                if (h_last && v_last) begin
                    if (pend_q) begin
                        commit = 1'b1;
                        pend_d = 1'b0;
                        err_d  = ~sh_ok;
                        if (!sh_ok) state_d = IDLE_S;
                    end
                    if (!en_i) state_d = IDLE_S;
                end
            end
            default: state_d = IDLE_S;
        endcase
        // A write always leaves a pending set, even when it lands on a commit cycle.
        if (we_i) pend_d = 1'b1;
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            sh_h_q   <= '0;
            sh_v_q   <= '0;
            act_h_q  <= '0;
            act_v_q  <= '0;
            act_ok_q <= 1'b0;
            htot_q   <= '0;
            vtot_q   <= '0;
            pend_q   <= 1'b0;
            err_q    <= 1'b0;
            state_q  <= IDLE_S;
            hcnt_q   <= '0;
            vcnt_q   <= '0;
        end else begin
            if (we_i) begin
                sh_h_q <= '{d: vga_field_t'(hd_i), f: vga_field_t'(hf_i),
                            r: vga_field_t'(hr_i), b: vga_field_t'(hb_i)};
                sh_v_q <= '{d: vga_field_t'(vd_i), f: vga_field_t'(vf_i),
                            r: vga_field_t'(vr_i), b: vga_field_t'(vb_i)};
            end
            if (commit) begin
                act_h_q  <= sh_h_q;
                act_v_q  <= sh_v_q;
                act_ok_q <= sh_ok;
                htot_q   <= sh_hsum[H_W:0];
                vtot_q   <= sh_vsum[V_W:0];
            end
            pend_q  <= pend_d;
            err_q   <= err_d;
            state_q <= state_d;
            hcnt_q  <= hcnt_d;
            vcnt_q  <= vcnt_d;
        end
    end

    // Region decode done at 18 bits so porch sums never wrap.
    vga_sum_t hc_x, vc_x;
    logic     de_raw, hs_in, vs_in;
    assign hc_x   = vga_sum_t'(hcnt_q);
    assign vc_x   = vga_sum_t'(vcnt_q);
    assign de_raw = running && (hc_x < {2'b00, act_h_q.d}) && (vc_x < {2'b00, act_v_q.d});
    assign hs_in  = running && (hc_x >= {2'b00, act_h_q.d} + {2'b00, act_h_q.f}) &&
                    (hc_x < {2'b00, act_h_q.d} + {2'b00, act_h_q.f} + {2'b00, act_h_q.r});
    assign vs_in  = running && (vc_x >= {2'b00, act_v_q.d} + {2'b00, act_v_q.f}) &&
                    (vc_x < {2'b00, act_v_q.d} + {2'b00, act_v_q.f} + {2'b00, act_v_q.r});

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            hs_q <= ~HS_POL;
            vs_q <= ~VS_POL;
            de_q <= 1'b0;
        end else begin
            hs_q <= hs_in ? HS_POL : ~HS_POL;
            vs_q <= vs_in ? VS_POL : ~VS_POL;
            de_q <= de_raw;
        end
    end

    vga_delay_line #(
        .WIDTH    (3),
        .DEPTH    (PIPE_DEPTH),
        .RESET_VAL({~HS_POL, ~VS_POL, 1'b0})
    ) u_delay (
        .clk_i  (clk_i),
        .arstn_i(arstn_i),
        .d_i    ({hs_q, vs_q, de_q}),
        .q_o    ({hs_o, vs_o, de_o})
    );

    assign cfg_pending_o = pend_q;
    assign cfg_err_o     = err_q;
    assign running_o     = running;
    assign hcount_o      = hcnt_q;
    assign vcount_o      = vcnt_q;
    assign line_start_o  = running && (hcnt_q == '0);
    assign frame_start_o = running && (hcnt_q == '0) && (vcnt_q == '0);
    assign rgb_o         = de_o ? rgb_i : '0;

endmodule
